// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one external signed adder among NUM_REQ requesters.
// Operands are registered onto the adder; the sum returns with a one-hot strobe.
module adder_rr_sched #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 16,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
  output logic [DATA_W-1:0]         add_a_o,
  output logic [DATA_W-1:0]         add_b_o,
  input  logic [DATA_W:0]           add_c_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W:0]           rsp_data_o,
  output logic                      busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [DATA_W-1:0]   add_a_q, add_a_d;
  logic [DATA_W-1:0]   add_b_q, add_b_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W:0]     rsp_data_q, rsp_data_d;

  logic [DATA_W-1:0]   op_a [NUM_REQ];
  logic [DATA_W-1:0]   op_b [NUM_REQ];
  logic                gnt_found;
  logic [IDX_W-1:0]    gnt_idx;
  logic [IDX_W-1:0]    cand_idx;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic [NUM_REQ-1:0]  owner_oh;
  logic                grant_en;
  logic [IDX_W-1:0]    ptr_next;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_a[i] = req_a_i[i*DATA_W +: DATA_W];
    assign op_b[i] = req_b_i[i*DATA_W +: DATA_W];
  end

  // First valid requester found scanning upward from the pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid_i[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    gnt_oh            = '0;
    gnt_oh[gnt_idx]   = 1'b1;
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  assign grant_en    = !rst_i && gnt_found && (state_q != S_EXEC);
  assign req_ready_o = grant_en ? gnt_oh : '0;
  assign ptr_next    = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (grant_en) begin
          add_a_d = op_a[gnt_idx];
          add_b_d = op_b[gnt_idx];
          owner_d = gnt_idx;
          ptr_d   = ptr_next;
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        rsp_data_d  = add_c_i;
        rsp_valid_d = owner_oh;
        state_d     = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign add_a_o     = add_a_q;
  assign add_b_o     = add_b_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = (state_q == S_EXEC) || (state_q == S_DONE);

endmodule
